// File: rtl/dsmod_ctrl_pkg.sv
// Shared types and constants for the delta-sigma playback controller.
package dsmod_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

    localparam logic [15:0] MIDSCALE   = 16'h8000;
    localparam logic [3:0]  SH_MAX     = 4'd8;
    localparam int          FIFO_DEPTH = 2;

    // Pull a sample toward midscale by 2^-sh; the 17-bit signed difference keeps the result in range.
    function automatic logic [15:0] scale_sample(input logic [15:0] s, input logic [3:0] sh);
        logic signed [16:0] diff;
        diff = $signed({1'b0, s}) - $signed({1'b0, MIDSCALE});
        return MIDSCALE + 16'(diff >>> sh);
    endfunction
endpackage

// File: rtl/dsmod_fifo2.sv
// Two-entry sample FIFO with synchronous reset and flush; head entry is always visible on data.
module dsmod_fifo2
    import dsmod_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] wdata,
    output logic        full,
    output logic        empty,
    output logic [15:0] data
);
    logic [15:0] mem [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign full    = (count == 2'(FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign data    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/dsmod_ctrl.sv
// Playback controller feeding an external delta-sigma modulator with soft ramp-up and ramp-down.
module dsmod_ctrl
    import dsmod_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_mode_req,
    input  logic [5:0]  i_osr,
    input  logic [15:0] i_smp_data,
    input  logic        i_smp_valid,
    output logic        o_smp_ready,
    output logic [15:0] o_ds_data,
    output logic        o_ds_mode,
    output logic        o_ds_rst_n,
    input  logic        i_uf_clr,
    output logic        o_underflow,
    output logic        o_busy
);
    state_t      state;
    logic [3:0]  sh;
    logic [7:0]  cnt;
    logic [7:0]  term;
    logic [15:0] last;

    logic [5:0]  osr_eff;
    logic [7:0]  term_next;
    logic        tick;
    logic        push;
    logic        pop;
    logic        to_idle;
    logic [3:0]  sh_up;
    logic [3:0]  sh_dn;
    logic [15:0] sample;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_data;

    assign osr_eff     = (i_osr == 6'd0) ? 6'd1 : i_osr;
    assign term_next   = {osr_eff, 2'b00} - 8'd1;
    assign tick        = (state != IDLE) && (cnt == term);
    assign pop         = tick && !fifo_empty;
    assign to_idle     = tick && (state == RAMP_DOWN) && (sh >= SH_MAX - 4'd1);
    assign sh_up       = (sh >= SH_MAX) ? SH_MAX : sh + 4'd1;
    assign sh_dn       = (sh == 4'd0) ? 4'd0 : sh - 4'd1;
    assign sample      = fifo_empty ? last : fifo_data;
    assign o_smp_ready = !fifo_full && (state == RAMP_UP || state == RUN);
    assign push        = i_smp_valid && o_smp_ready;
    assign o_busy      = (state != IDLE);

    dsmod_fifo2 u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (to_idle),
        .push  (push),
        .pop   (pop),
        .wdata (i_smp_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .data  (fifo_data)
    );

    // The period is re-latched only in IDLE or at a wrap, so i_osr edits never cut a period short.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            sh          <= SH_MAX;
            cnt         <= 8'd0;
            term        <= 8'd3;
            last        <= MIDSCALE;
            o_ds_data   <= MIDSCALE;
            o_ds_mode   <= 1'b0;
            o_ds_rst_n  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (state == IDLE || tick) begin
                cnt  <= 8'd0;
                term <= term_next;
            end else begin
                cnt <= cnt + 8'd1;
            end

            if (pop)  last      <= fifo_data;
            if (tick) o_ds_data <= scale_sample(sample, sh);

            o_underflow <= (tick && state == RUN && fifo_empty) || (o_underflow && !i_uf_clr);

            case (state)
                IDLE: begin
                    if (i_en) begin
                        state      <= RAMP_UP;
                        sh         <= SH_MAX;
                        o_ds_mode  <= i_mode_req;
                        o_ds_rst_n <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (tick) begin
                        sh <= sh_dn;
                        if (sh_dn == 4'd0) state <= RUN;
                    end
                    if (!i_en) state <= RAMP_DOWN;
                end
                RUN: begin
                    if (!i_en) state <= RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    // Reaching full attenuation wins over a re-enable on the same tick.
                    if (to_idle) begin
                        state      <= IDLE;
                        sh         <= SH_MAX;
                        o_ds_rst_n <= 1'b0;
                        o_ds_data  <= MIDSCALE;
                    end else begin
                        if (tick) sh <= sh_up;
                        if (i_en) state <= RAMP_UP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsmod_ctrl.sv
// Scoreboard bench for dsmod_ctrl: directed stimulus queues expected outputs by cycle, a monitor compares them.
module tb_dsmod_ctrl;
    localparam int K_DATA  = 0;
    localparam int K_RSTN  = 1;
    localparam int K_READY = 2;
    localparam int K_BUSY  = 3;
    localparam int K_UF    = 4;
    localparam int K_MODE  = 5;

    logic        i_clk       = 1'b0;
    logic        i_rst       = 1'b1;
    logic        i_en        = 1'b0;
    logic        i_mode_req  = 1'b0;
    logic [5:0]  i_osr       = 6'd2;
    logic [15:0] i_smp_data  = 16'h8000;
    logic        i_smp_valid = 1'b0;
    logic        i_uf_clr    = 1'b0;
    logic        o_smp_ready;
    logic [15:0] o_ds_data;
    logic        o_ds_mode;
    logic        o_ds_rst_n;
    logic        o_underflow;
    logic        o_busy;

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] value;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   base   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    dsmod_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_mode_req  (i_mode_req),
        .i_osr       (i_osr),
        .i_smp_data  (i_smp_data),
        .i_smp_valid (i_smp_valid),
        .o_smp_ready (o_smp_ready),
        .o_ds_data   (o_ds_data),
        .o_ds_mode   (o_ds_mode),
        .o_ds_rst_n  (o_ds_rst_n),
        .i_uf_clr    (i_uf_clr),
        .o_underflow (o_underflow),
        .o_busy      (o_busy)
    );

    task automatic applyStimulus(input logic en, input logic mode_req, input logic [5:0] osr,
                                 input logic [15:0] smp, input logic valid, input logic uf_clr);
        i_en        = en;
        i_mode_req  = mode_req;
        i_osr       = osr;
        i_smp_data  = smp;
        i_smp_valid = valid;
        i_uf_clr    = uf_clr;
    endtask

    task automatic waitUntil(input int off);
        while (cyc < base + off) @(negedge i_clk);
    endtask

    // Entries stay ordered by due cycle so the monitor only ever looks at the front.
    task automatic expectAt(input int off, input int kind, input logic [15:0] value, input string name);
        exp_t e;
        int   i;
        e.due   = base + off;
        e.kind  = kind;
        e.value = value;
        e.name  = $sformatf("%s@%0d", name, off);
        i = 0;
        while (i < sb.size() && sb[i].due <= e.due) i++;
        sb.insert(i, e);
    endtask

    function automatic logic [15:0] outputOf(input int kind);
        case (kind)
            K_DATA:  return o_ds_data;
            K_RSTN:  return {15'd0, o_ds_rst_n};
            K_READY: return {15'd0, o_smp_ready};
            K_BUSY:  return {15'd0, o_busy};
            K_UF:    return {15'd0, o_underflow};
            default: return {15'd0, o_ds_mode};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    always @(negedge i_clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checkOutput(e.name, outputOf(e.kind), e.value);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        applyStimulus(1'b0, 1'b0, 6'd2, 16'h8000, 1'b0, 1'b0);
        i_rst = 1'b1;
        waitUntil(2);
        expectAt(3, K_DATA,  16'h8000, "rst_data");
        expectAt(3, K_RSTN,  16'h0000, "rst_rstn");
        expectAt(3, K_READY, 16'h0000, "rst_ready");
        expectAt(3, K_BUSY,  16'h0000, "rst_busy");
        expectAt(3, K_UF,    16'h0000, "rst_uf");
        expectAt(3, K_MODE,  16'h0000, "rst_mode");
        waitUntil(4);
        i_rst = 1'b0;
        waitUntil(6);
        base = cyc;

        $display("[TB] full-scale ramp-up, osr=2");
        applyStimulus(1'b1, 1'b0, 6'd2, 16'hFFFF, 1'b1, 1'b0);
        expectAt(1, K_RSTN,  16'h0001, "up_rstn");
        expectAt(1, K_BUSY,  16'h0001, "up_busy");
        expectAt(1, K_MODE,  16'h0000, "up_mode");
        expectAt(1, K_READY, 16'h0001, "up_ready");
        expectAt(3, K_READY, 16'h0000, "full_ready");
        expectAt(9,  K_DATA, 16'h807F, "ramp_sh8");
        expectAt(13, K_DATA, 16'h807F, "hold_sh8");
        expectAt(17, K_DATA, 16'h80FF, "ramp_sh7");
        expectAt(25, K_DATA, 16'h81FF, "ramp_sh6");
        expectAt(33, K_DATA, 16'h83FF, "ramp_sh5");
        expectAt(41, K_DATA, 16'h87FF, "ramp_sh4");
        expectAt(49, K_DATA, 16'h8FFF, "ramp_sh3");
        expectAt(57, K_DATA, 16'h9FFF, "ramp_sh2");
        expectAt(65, K_DATA, 16'hBFFF, "ramp_sh1");
        expectAt(73, K_DATA, 16'hFFFF, "run_sh0");

        waitUntil(73);
        $display("[TB] run: starve the FIFO, underflow and clear");
        applyStimulus(1'b1, 1'b1, 6'd2, 16'h1234, 1'b1, 1'b0);
        expectAt(80, K_MODE, 16'h0000, "mode_ignored_run");
        expectAt(81, K_DATA, 16'hFFFF, "run_old_entry");
        waitUntil(81);
        applyStimulus(1'b1, 1'b1, 6'd2, 16'h1234, 1'b0, 1'b0);
        expectAt(89,  K_DATA, 16'h1234, "run_last_pop");
        expectAt(89,  K_UF,   16'h0000, "uf_not_yet");
        expectAt(97,  K_DATA, 16'h1234, "run_empty_hold");
        expectAt(97,  K_UF,   16'h0001, "uf_set");
        expectAt(105, K_UF,   16'h0001, "uf_sticky");
        waitUntil(106);
        applyStimulus(1'b1, 1'b1, 6'd2, 16'h1234, 1'b0, 1'b1);
        expectAt(107, K_UF, 16'h0000, "uf_cleared");
        waitUntil(107);
        applyStimulus(1'b1, 1'b1, 6'd2, 16'h1234, 1'b0, 1'b0);
        waitUntil(112);
        applyStimulus(1'b1, 1'b1, 6'd2, 16'h1234, 1'b0, 1'b1);
        expectAt(113, K_UF,   16'h0001, "uf_set_wins");
        expectAt(114, K_UF,   16'h0000, "uf_clear_again");
        expectAt(114, K_MODE, 16'h0000, "mode_still_old");

        waitUntil(114);
        $display("[TB] ramp-down from run with negative sample");
        applyStimulus(1'b0, 1'b1, 6'd2, 16'h1234, 1'b0, 1'b0);
        expectAt(116, K_READY, 16'h0000, "down_ready");
        expectAt(120, K_BUSY,  16'h0001, "down_busy");
        expectAt(121, K_DATA,  16'h1234, "down_sh0");
        expectAt(121, K_UF,    16'h0000, "down_no_uf");
        expectAt(129, K_DATA,  16'h491A, "down_sh1");
        expectAt(145, K_DATA,  16'h7246, "down_sh3");
        expectAt(161, K_DATA,  16'h7C91, "down_sh5");
        expectAt(169, K_DATA,  16'h7E48, "down_sh6");
        expectAt(176, K_RSTN,  16'h0001, "down_rstn_high");
        expectAt(177, K_DATA,  16'h8000, "idle_data");
        expectAt(177, K_RSTN,  16'h0000, "idle_rstn");
        expectAt(177, K_BUSY,  16'h0000, "idle_busy");

        waitUntil(177);
        $display("[TB] zero stream, abort ramp-up at sh=5");
        applyStimulus(1'b1, 1'b1, 6'd2, 16'h0000, 1'b1, 1'b0);
        expectAt(178, K_MODE, 16'h0001, "mode_latched");
        expectAt(178, K_RSTN, 16'h0001, "rstn_again");
        expectAt(186, K_DATA, 16'h7F80, "zero_sh8");
        expectAt(194, K_DATA, 16'h7F00, "zero_sh7");
        expectAt(202, K_DATA, 16'h7E00, "zero_sh6");
        waitUntil(202);
        applyStimulus(1'b0, 1'b1, 6'd2, 16'h0000, 1'b0, 1'b0);
        expectAt(203, K_READY, 16'h0000, "abort_ready");
        expectAt(210, K_DATA,  16'h7C00, "abort_sh5");
        expectAt(218, K_DATA,  16'h7E00, "abort_sh6");
        expectAt(226, K_DATA,  16'h8000, "abort_idle_data");
        expectAt(226, K_RSTN,  16'h0000, "abort_idle_rstn");
        expectAt(226, K_BUSY,  16'h0000, "abort_idle_busy");

        waitUntil(226);
        $display("[TB] flush of a stale entry on idle entry");
        applyStimulus(1'b1, 1'b0, 6'd2, 16'hFFFF, 1'b1, 1'b0);
        expectAt(227, K_MODE, 16'h0000, "mode_relatched");
        waitUntil(228);
        applyStimulus(1'b1, 1'b0, 6'd2, 16'h0000, 1'b1, 1'b0);
        waitUntil(229);
        applyStimulus(1'b0, 1'b0, 6'd2, 16'h0000, 1'b0, 1'b0);
        expectAt(235, K_DATA, 16'h8000, "flush_idle_data");
        expectAt(235, K_BUSY, 16'h0000, "flush_idle_busy");
        waitUntil(235);
        applyStimulus(1'b1, 1'b0, 6'd2, 16'h0000, 1'b0, 1'b0);
        expectAt(244, K_DATA, 16'h807F, "flushed_uses_last");
        expectAt(244, K_UF,   16'h0000, "up_empty_no_uf");
        waitUntil(244);
        applyStimulus(1'b0, 1'b0, 6'd2, 16'h0000, 1'b0, 1'b0);
        expectAt(252, K_DATA, 16'h8000, "sh7_idle_data");
        expectAt(252, K_BUSY, 16'h0000, "sh7_idle_busy");

        waitUntil(252);
        $display("[TB] osr=0 period and osr change at wrap");
        applyStimulus(1'b1, 1'b0, 6'd0, 16'hFFFF, 1'b1, 1'b0);
        expectAt(257, K_DATA, 16'h807F, "osr0_tick1");
        expectAt(261, K_DATA, 16'h80FF, "osr0_tick2");
        waitUntil(262);
        applyStimulus(1'b1, 1'b0, 6'd2, 16'hFFFF, 1'b1, 1'b0);
        expectAt(265, K_DATA, 16'h81FF, "osr_old_period");
        expectAt(269, K_DATA, 16'h81FF, "osr_new_hold");
        expectAt(273, K_DATA, 16'h83FF, "osr_new_period");

        waitUntil(274);
        $display("[TB] reset mid-operation");
        i_rst = 1'b1;
        expectAt(275, K_DATA,  16'h8000, "mrst_data");
        expectAt(275, K_RSTN,  16'h0000, "mrst_rstn");
        expectAt(275, K_BUSY,  16'h0000, "mrst_busy");
        expectAt(275, K_READY, 16'h0000, "mrst_ready");
        expectAt(275, K_MODE,  16'h0000, "mrst_mode");
        expectAt(275, K_UF,    16'h0000, "mrst_uf");
        waitUntil(276);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge i_clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: never compared, expected 0x%h", e.name, e.value);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsmod_ctrl.md
DSMOD_CTRL -- requirements
Module: dsmod_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk, i_rst.
REQ-002 i_clk  in  1  block clock; it is also the modulator clock.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_en  in  1  enables playback; level-sensitive.
REQ-005 i_mode_req  in  1  requested modulator order (0 = 1st order, 1 = 2nd order).
REQ-006 i_osr  in  6  sample period = 4*i_osr clocks; i_osr = 0 is treated as 1.
REQ-007 i_smp_data  in  16  unsigned sample, midscale 0x8000.
REQ-008 i_smp_valid  in  1  sample offered.
REQ-009 o_smp_ready  out  1  sample accepted when valid and ready are both high on a rising edge.
REQ-010 o_ds_data  out  16  data to the modulator input.
REQ-011 o_ds_mode  out  1  order sent to the modulator.
REQ-012 o_ds_rst_n  out  1  active-low reset to the modulator.
REQ-013 i_uf_clr  in  1  clears o_underflow.
REQ-014 o_underflow  out  1  sticky underflow flag.
REQ-015 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 The block SHALL contain a 2-entry sample FIFO; o_smp_ready SHALL equal (FIFO not full) AND (state is RAMP_UP or RUN).
REQ-017 The period counter SHALL count 0..4*max(i_osr,1)-1, wrap to 0, and assert tick for one cycle at the terminal count.
REQ-018 The period counter SHALL be held at 0 in IDLE, and i_osr changes SHALL take effect at the next wrap.
REQ-019 States SHALL be IDLE, RAMP_UP, RUN and RAMP_DOWN, with shift register sh in the range 0..8.
REQ-020 IDLE -> RAMP_UP on i_en=1: latch o_ds_mode from i_mode_req, set sh=8, drive o_ds_rst_n=1 from the next cycle.
REQ-021 i_mode_req SHALL be ignored outside IDLE.
REQ-022 On each tick in RAMP_UP: pop the FIFO and decrement sh.
REQ-023 When sh reaches 0 in RAMP_UP, the state SHALL go to RUN.
REQ-024 On each tick in RUN: pop the FIFO.
REQ-025 On each tick in RAMP_DOWN: pop the FIFO if it is non-empty and increment sh; when sh reaches 8, go to IDLE.
REQ-026 i_en=0 in RAMP_UP or RUN SHALL cause RAMP_DOWN with the current sh retained.
REQ-027 i_en=1 in RAMP_DOWN SHALL cause RAMP_UP with the current sh retained.
REQ-028 On entry to IDLE: flush the FIFO; o_ds_rst_n=0 and o_ds_data=0x8000 in the same cycle.
REQ-029 Output rule: the cycle after a tick, o_ds_data SHALL equal 0x8000 + ((s - 0x8000) >>> sh).
REQ-030 In REQ-029, s is the popped sample, or the last sample if the FIFO is empty (0x8000 if none yet).
REQ-031 REQ-029 SHALL use a 17-bit signed difference and an arithmetic shift; the result always fits 16 bits and SHALL NOT saturate.
REQ-032 o_ds_data SHALL hold between ticks.
REQ-033 Underflow: a tick in RUN with an empty FIFO SHALL set o_underflow.
REQ-034 An empty FIFO on a tick in RAMP_UP or RAMP_DOWN SHALL NOT set o_underflow.
REQ-035 i_uf_clr SHALL clear o_underflow; a simultaneous set SHALL win.
REQ-036 Simultaneous push and pop with 1 entry SHALL keep the count at 1; a push with 0 entries coincident with a tick SHALL be popped on the next tick, not this one.

Reset
REQ-037 While i_rst=1 the block SHALL hold: state IDLE, sh=8, FIFO empty, counter 0, last sample 0x8000.
REQ-038 While i_rst=1 the outputs SHALL be: o_ds_data=0x8000, o_ds_mode=0, o_ds_rst_n=0, o_smp_ready=0, o_underflow=0, o_busy=0.
REQ-039 Reset asserted mid-operation SHALL override all activity in the same edge; no ramp-down occurs.

Structure
REQ-040 Package dsmod_ctrl_pkg SHALL hold the state enum, MIDSCALE=16'h8000, SH_MAX=8 and FIFO_DEPTH=2.
REQ-041 The FIFO SHALL be sub-module dsmod_fifo2 (push, pop, full, empty, data), with synchronous active-high reset and a flush input.
REQ-042 The modulator SHALL be instantiated by the parent, not inside this block.

Verification
REQ-043 Reset -> o_ds_data=0x8000, o_ds_rst_n=0, o_smp_ready=0, o_busy=0.
REQ-044 i_osr=2, i_en=1, constant 0xFFFF stream -> o_ds_data after the ticks is 0x8000+(0x7FFF>>>8)=0x807F, ... 0xBFFF, 0xFFFF; the state reaches RUN at the 8th tick; ticks are 8 clocks apart.
REQ-045 Stream 0x0000 through the ramp -> o_ds_data=0x7F80 at sh=8 and 0x0000 in RUN; no overflow.
REQ-046 Stop i_smp_valid in RUN with last sample 0x1234 -> o_ds_data stays 0x1234; o_underflow=1 until i_uf_clr.
REQ-047 Deassert i_en at sh=5 in RAMP_UP -> sh climbs 6, 7, 8; IDLE; o_ds_rst_n=0; the FIFO is flushed.
REQ-048 Toggle i_mode_req in RUN then cycle i_en -> o_ds_mode changes only on the new IDLE -> RAMP_UP transition.
